// File: rtl/bsg_mul_iterative_result_queue.sv
// bsg_mul_iterative_result_queue
// Credit-based wrapper around an iterative multiplier. It decodes operand
// signedness, remembers {op, tag} for each in-flight request, selects the
// low or high product half on completion and returns results in issue order.
// Optional build macro: BSG_MUL_ITERATIVE_RESULT_QUEUE_OVF_EN adds a per-entry
// overflow bit (upper half nonzero on MUL); when undefined, ovf_o is tied to 0.
module bsg_mul_iterative_result_queue #(
  parameter int width_p     = 32,
  parameter int els_p       = 2,
  parameter int tag_width_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     issue_v_i,
  input  logic [1:0]               issue_op_i,
  input  logic [tag_width_p-1:0]   issue_tag_i,
  output logic                     issue_ready_o,
  output logic                     opA_is_signed_o,
  output logic                     opB_is_signed_o,
  input  logic                     mul_v_i,
  input  logic [2*width_p-1:0]     mul_result_i,
  output logic                     mul_yumi_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic [tag_width_p-1:0]   tag_o,
  output logic                     ovf_o,
  input  logic                     ready_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  localparam logic [1:0] op_mul_lp    = 2'b00;
  localparam logic [1:0] op_mulh_lp   = 2'b01;
  localparam logic [1:0] op_mulhsu_lp = 2'b10;

  // Storage: op-info queue and result queue share the same depth
  logic [1:0]             info_op_mem  [els_p];
  logic [tag_width_p-1:0] info_tag_mem [els_p];
  logic [width_p-1:0]     res_data_mem [els_p];
  logic [tag_width_p-1:0] res_tag_mem  [els_p];

  logic [ptr_w_lp-1:0] info_wr_ptr_reg, info_wr_ptr_next;
  logic [ptr_w_lp-1:0] info_rd_ptr_reg, info_rd_ptr_next;
  logic [ptr_w_lp-1:0] res_wr_ptr_reg,  res_wr_ptr_next;
  logic [ptr_w_lp-1:0] res_rd_ptr_reg,  res_rd_ptr_next;
  logic [cnt_w_lp-1:0] info_count_reg,  info_count_next;
  logic [cnt_w_lp-1:0] res_count_reg,   res_count_next;

  logic [cnt_w_lp:0]   occupancy;
  logic                info_fire;
  logic                res_pop;
  logic [1:0]          head_op;
  logic [width_p-1:0]  prod_lo;
  logic [width_p-1:0]  prod_hi;
  logic [width_p-1:0]  sel_data;

  // Signedness only depends on the op being issued this cycle
  assign opA_is_signed_o = (issue_op_i == op_mulh_lp) || (issue_op_i == op_mulhsu_lp);
  assign opB_is_signed_o = (issue_op_i == op_mulh_lp);

  // Credit check uses registered counts only, so a pop frees a slot next cycle
  assign occupancy     = {1'b0, info_count_reg} + {1'b0, res_count_reg};
  assign issue_ready_o = occupancy < (cnt_w_lp+1)'(els_p);
  assign info_fire     = issue_v_i & issue_ready_o;

  // A result is only consumed when we know which request it belongs to
  assign mul_yumi_o = mul_v_i & (info_count_reg != '0) & reset_n_i;

  assign head_op  = info_op_mem[info_rd_ptr_reg];
  assign prod_lo  = mul_result_i[width_p-1:0];
  assign prod_hi  = mul_result_i[2*width_p-1:width_p];
  assign sel_data = (head_op == op_mul_lp) ? prod_lo : prod_hi;

  assign v_o     = (res_count_reg != '0);
  assign res_pop = v_o & ready_i;
  // Outputs are forced to zero while empty so stale entries never leak out
  assign data_o  = v_o ? res_data_mem[res_rd_ptr_reg] : '0;
  assign tag_o   = v_o ? res_tag_mem[res_rd_ptr_reg]  : '0;

`ifdef BSG_MUL_ITERATIVE_RESULT_QUEUE_OVF_EN
  logic res_ovf_mem [els_p];
  logic sel_ovf;

  assign sel_ovf = (head_op == op_mul_lp) && (prod_hi != '0);
  assign ovf_o   = v_o & res_ovf_mem[res_rd_ptr_reg];

  // Overflow flag travels with its result entry
  always_ff @(posedge clk_i) begin
    if (mul_yumi_o) res_ovf_mem[res_wr_ptr_reg] <= sel_ovf;
  end
`else
  assign ovf_o = 1'b0;
`endif

  // Queue payload writes; no reset needed since counts gate every read
  always_ff @(posedge clk_i) begin
    if (info_fire) begin
      info_op_mem[info_wr_ptr_reg]  <= issue_op_i;
      info_tag_mem[info_wr_ptr_reg] <= issue_tag_i;
    end
    if (mul_yumi_o) begin
      res_data_mem[res_wr_ptr_reg] <= sel_data;
      res_tag_mem[res_wr_ptr_reg]  <= info_tag_mem[info_rd_ptr_reg];
    end
  end

  // Next pointer/count values; simultaneous push and pop leave counts unchanged
  always_comb begin
    info_wr_ptr_next = info_wr_ptr_reg;
    info_rd_ptr_next = info_rd_ptr_reg;
    res_wr_ptr_next  = res_wr_ptr_reg;
    res_rd_ptr_next  = res_rd_ptr_reg;
    info_count_next  = info_count_reg;
    res_count_next   = res_count_reg;

    if (info_fire)  info_wr_ptr_next = info_wr_ptr_reg + ptr_w_lp'(1);
    if (mul_yumi_o) info_rd_ptr_next = info_rd_ptr_reg + ptr_w_lp'(1);
    if (mul_yumi_o) res_wr_ptr_next  = res_wr_ptr_reg + ptr_w_lp'(1);
    if (res_pop)    res_rd_ptr_next  = res_rd_ptr_reg + ptr_w_lp'(1);

    if (info_fire && !mul_yumi_o)      info_count_next = info_count_reg + cnt_w_lp'(1);
    else if (!info_fire && mul_yumi_o) info_count_next = info_count_reg - cnt_w_lp'(1);

    if (mul_yumi_o && !res_pop)      res_count_next = res_count_reg + cnt_w_lp'(1);
    else if (!mul_yumi_o && res_pop) res_count_next = res_count_reg - cnt_w_lp'(1);
  end

  // Pointer/count registers; reset drops every queued op and result
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      info_wr_ptr_reg <= '0;
      info_rd_ptr_reg <= '0;
      res_wr_ptr_reg  <= '0;
      res_rd_ptr_reg  <= '0;
      info_count_reg  <= '0;
      res_count_reg   <= '0;
    end else begin
      info_wr_ptr_reg <= info_wr_ptr_next;
      info_rd_ptr_reg <= info_rd_ptr_next;
      res_wr_ptr_reg  <= res_wr_ptr_next;
      res_rd_ptr_reg  <= res_rd_ptr_next;
      info_count_reg  <= info_count_next;
      res_count_reg   <= res_count_next;
    end
  end

endmodule

// File: tb/tb_bsg_mul_iterative_result_queue.sv
// Testbench for bsg_mul_iterative_result_queue: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_bsg_mul_iterative_result_queue;

  localparam int W   = 32;
  localparam int ELS = 2;
  localparam int TW  = 4;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          issue_v_i;
  logic [1:0]    issue_op_i;
  logic [TW-1:0] issue_tag_i;
  logic          issue_ready_o;
  logic          opA_is_signed_o;
  logic          opB_is_signed_o;
  logic          mul_v_i;
  logic [2*W-1:0] mul_result_i;
  logic          mul_yumi_o;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic [TW-1:0] tag_o;
  logic          ovf_o;
  logic          ready_i;

  always #5 clk = ~clk;

  bsg_mul_iterative_result_queue #(
    .width_p    (W),
    .els_p      (ELS),
    .tag_width_p(TW)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .issue_v_i      (issue_v_i),
    .issue_op_i     (issue_op_i),
    .issue_tag_i    (issue_tag_i),
    .issue_ready_o  (issue_ready_o),
    .opA_is_signed_o(opA_is_signed_o),
    .opB_is_signed_o(opB_is_signed_o),
    .mul_v_i        (mul_v_i),
    .mul_result_i   (mul_result_i),
    .mul_yumi_o     (mul_yumi_o),
    .v_o            (v_o),
    .data_o         (data_o),
    .tag_o          (tag_o),
    .ovf_o          (ovf_o),
    .ready_i        (ready_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]    op;
    logic [TW-1:0] tag;
  } info_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          ovf;
  } res_t;

  info_t info_q[$];
  res_t  res_q[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Result the model expects for a request completing with product r
  function automatic res_t make_res(info_t i, logic [63:0] r);
    res_t o;
    logic [31:0] hi;
    logic [31:0] lo;
    hi = r[63:32];
    lo = r[31:0];
    o.tag  = i.tag;
    o.data = (i.op == 2'b00) ? lo : hi;
`ifdef BSG_MUL_ITERATIVE_RESULT_QUEUE_OVF_EN
    o.ovf = (i.op == 2'b00) && (hi != 32'd0);
`else
    o.ovf = 1'b0;
`endif
    return o;
  endfunction

  // One clock: check outputs against the model, then advance the model
  task automatic step();
    bit    do_yumi;
    bit    do_pop;
    bit    do_iss;
    info_t it;
    res_t  rt;
    #2;
    chk("v_o", 64'(v_o), 64'(res_q.size() != 0));
    chk("issue_ready_o", 64'(issue_ready_o), 64'((info_q.size() + res_q.size()) < ELS));
    chk("mul_yumi_o", 64'(mul_yumi_o), 64'(mul_v_i && (info_q.size() != 0) && reset_n_i));
    chk("opA_is_signed_o", 64'(opA_is_signed_o), 64'(issue_op_i == 2'b01 || issue_op_i == 2'b10));
    chk("opB_is_signed_o", 64'(opB_is_signed_o), 64'(issue_op_i == 2'b01));
    if (res_q.size() != 0) begin
      chk("data_o", 64'(data_o), 64'(res_q[0].data));
      chk("tag_o",  64'(tag_o),  64'(res_q[0].tag));
      chk("ovf_o",  64'(ovf_o),  64'(res_q[0].ovf));
    end
    @(posedge clk);
    if (!reset_n_i) begin
      info_q.delete();
      res_q.delete();
    end else begin
      do_yumi = mul_v_i && (info_q.size() != 0);
      do_pop  = (res_q.size() != 0) && ready_i;
      do_iss  = issue_v_i && ((info_q.size() + res_q.size()) < ELS);
      if (do_pop) rt = res_q.pop_front();
      if (do_yumi) begin
        it = info_q.pop_front();
        res_q.push_back(make_res(it, mul_result_i));
      end
      if (do_iss) begin
        it.op  = issue_op_i;
        it.tag = issue_tag_i;
        info_q.push_back(it);
      end
    end
    #1;
  endtask

  initial begin
    reset_n_i    = 1'b0;
    issue_v_i    = 1'b0;
    issue_op_i   = 2'b00;
    issue_tag_i  = '0;
    mul_v_i      = 1'b0;
    mul_result_i = '0;
    ready_i      = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with a pending multiplier result
    mul_v_i = 1'b1;
    step();
    #1;
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_yumi", 64'(mul_yumi_o), 64'd0);
    chk("rst_data_o", 64'(data_o), 64'd0);
    chk("rst_tag_o", 64'(tag_o), 64'd0);
    chk("rst_ovf_o", 64'(ovf_o), 64'd0);

    // Multiplier result with nothing outstanding is not consumed
    reset_n_i = 1'b1;
    mul_v_i   = 1'b1;
    #1;
    chk("empty_info_yumi", 64'(mul_yumi_o), 64'd0);
    step();
    step();
    #1;
    chk("empty_info_v_o", 64'(v_o), 64'd0);
    mul_v_i = 1'b0;

    // MULHU tag 3: high half, valid one cycle after the handshake
    issue_v_i = 1'b1; issue_op_i = 2'b11; issue_tag_i = 4'd3;
    step();
    issue_v_i = 1'b0;
    mul_v_i = 1'b1; mul_result_i = 64'h0000_0001_0000_0000;
    #1;
    chk("mulhu_yumi", 64'(mul_yumi_o), 64'd1);
    chk("mulhu_v_before", 64'(v_o), 64'd0);
    step();
    mul_v_i = 1'b0;
    #1;
    chk("mulhu_v_after", 64'(v_o), 64'd1);
    chk("mulhu_data", 64'(data_o), 64'h0000_0001);
    chk("mulhu_tag", 64'(tag_o), 64'd3);
    step();

    // MUL tag 1: low half plus overflow indication
    issue_v_i = 1'b1; issue_op_i = 2'b00; issue_tag_i = 4'd1;
    step();
    issue_v_i = 1'b0;
    mul_v_i = 1'b1; mul_result_i = 64'h0000_0001_FFFF_FFFE;
    step();
    mul_v_i = 1'b0;
    #1;
    chk("mul_data", 64'(data_o), 64'hFFFF_FFFE);
    chk("mul_tag", 64'(tag_o), 64'd1);
`ifdef BSG_MUL_ITERATIVE_RESULT_QUEUE_OVF_EN
    chk("mul_ovf", 64'(ovf_o), 64'd1);
`else
    chk("mul_ovf", 64'(ovf_o), 64'd0);
`endif
    step();

    // Credits exhausted: third issue ignored, results drain in order
    ready_i = 1'b0;
    issue_v_i = 1'b1; issue_op_i = 2'b11; issue_tag_i = 4'd3;
    step();
    issue_op_i = 2'b00; issue_tag_i = 4'd5;
    step();
    #1;
    chk("credit_full_ready", 64'(issue_ready_o), 64'd0);
    issue_op_i = 2'b01; issue_tag_i = 4'd7;
    step();
    issue_v_i = 1'b0;
    mul_v_i = 1'b1; mul_result_i = {$urandom(), $urandom()};
    step();
    mul_result_i = {$urandom(), $urandom()};
    step();
    mul_v_i = 1'b0;
    #1;
    chk("hold_v_o", 64'(v_o), 64'd1);
    chk("hold_tag_first", 64'(tag_o), 64'd3);
    chk("hold_ready", 64'(issue_ready_o), 64'd0);
    step();
    #1;
    chk("hold_stable_tag", 64'(tag_o), 64'd3);
    ready_i = 1'b1;
    step();
    #1;
    chk("drain_tag_second", 64'(tag_o), 64'd5);
    chk("drain_ready_back", 64'(issue_ready_o), 64'd1);
    step();
    #1;
    chk("drain_empty_v", 64'(v_o), 64'd0);
    mul_v_i = 1'b1;
    step();
    mul_v_i = 1'b0;

    // Issue and completion in the same cycle, then push and pop together
    ready_i = 1'b0;
    issue_v_i = 1'b1; issue_op_i = 2'b10; issue_tag_i = 4'd9;
    step();
    issue_op_i = 2'b01; issue_tag_i = 4'd10;
    mul_v_i = 1'b1; mul_result_i = {$urandom(), $urandom()};
    step();
    issue_v_i = 1'b0; mul_v_i = 1'b0;
    #1;
    chk("pp_ready_full", 64'(issue_ready_o), 64'd0);
    chk("pp_tag_head", 64'(tag_o), 64'd9);
    ready_i = 1'b1;
    mul_v_i = 1'b1; mul_result_i = {$urandom(), $urandom()};
    #1;
    chk("pp_yumi", 64'(mul_yumi_o), 64'd1);
    step();
    mul_v_i = 1'b0;
    #1;
    chk("pp_v_stays", 64'(v_o), 64'd1);
    chk("pp_tag_next", 64'(tag_o), 64'd10);
    step();

    // Reset mid-operation discards a held result and a pending op
    ready_i = 1'b0;
    issue_v_i = 1'b1; issue_op_i = 2'b00; issue_tag_i = 4'd2;
    step();
    issue_tag_i = 4'd4;
    mul_v_i = 1'b1; mul_result_i = {$urandom(), $urandom()};
    step();
    issue_v_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    chk("midrst_yumi", 64'(mul_yumi_o), 64'd0);
    step();
    #1;
    chk("midrst_v_o", 64'(v_o), 64'd0);
    chk("midrst_ready", 64'(issue_ready_o), 64'd1);
    chk("midrst_yumi2", 64'(mul_yumi_o), 64'd0);
    reset_n_i = 1'b1; mul_v_i = 1'b0; ready_i = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset_n_i    = ($urandom_range(0, 49) != 0);
      issue_v_i    = 1'($urandom_range(0, 1));
      issue_op_i   = 2'($urandom_range(0, 3));
      issue_tag_i  = TW'($urandom_range(0, 15));
      mul_v_i      = 1'($urandom_range(0, 1));
      mul_result_i = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) mul_result_i[63:32] = '0;
      ready_i      = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
